// File: rtl/mem_arbiter_if.sv
// mem_arbiter_if: requester, memory-controller and status signals
// shared between the arbiter (slave) and its surroundings (master).
interface mem_arbiter_if #(
    parameter int ROW_BITS = 13,
    parameter int COL_BITS = 8
);
    logic                         WR_REQ;
    logic [15:0]                  WR_DATA;
    logic                         RD_REQ;
    logic                         MEM_BUSY;
    logic [15:0]                  MEM_RDATA;
    logic                         MEM_START;
    logic                         MEM_WE;
    logic [ROW_BITS+COL_BITS-1:0] MEM_ADDR;
    logic [15:0]                  MEM_WDATA;
    logic                         WR_ACK;
    logic                         RD_VALID;
    logic [15:0]                  RD_DATA;
    logic [ROW_BITS-1:0]          ROW_WRITE;
    logic [ROW_BITS-1:0]          ROW_READ;
    logic                         EMPTY;
    logic                         FULL;
    logic                         OVERRUN;

    modport slave (
        input  WR_REQ, WR_DATA, RD_REQ, MEM_BUSY, MEM_RDATA,
        output MEM_START, MEM_WE, MEM_ADDR, MEM_WDATA,
        output WR_ACK, RD_VALID, RD_DATA,
        output ROW_WRITE, ROW_READ, EMPTY, FULL, OVERRUN
    );

    modport master (
        output WR_REQ, WR_DATA, RD_REQ, MEM_BUSY, MEM_RDATA,
        input  MEM_START, MEM_WE, MEM_ADDR, MEM_WDATA,
        input  WR_ACK, RD_VALID, RD_DATA,
        input  ROW_WRITE, ROW_READ, EMPTY, FULL, OVERRUN
    );
endinterface

// File: rtl/mem_arbiter.sv
// mem_arbiter: ring-buffer arbiter between logger writes and downlink
// reads over a single memory port, with read-starvation guard.
module mem_arbiter #(
    parameter int ROW_BITS     = 13,
    parameter int COL_BITS     = 8,
    parameter int STARVE_LIMIT = 4
) (
    input logic          CLK_48MHZ,
    input logic          RESET,
    mem_arbiter_if.slave bus
);
    localparam int AW = ROW_BITS + COL_BITS;
    localparam int SW = (STARVE_LIMIT > 0) ? $clog2(STARVE_LIMIT + 1) : 1;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT_HI,
        WAIT_LO
    } state_t;

    state_t        state_q, state_d;
    logic [AW-1:0] wp_q, wp_d;
    logic [AW-1:0] rp_q, rp_d;
    logic [AW-1:0] addr_q, addr_d;
    logic [SW-1:0] starve_q, starve_d;
    logic          we_q, we_d;
    logic          start_q, start_d;
    logic          wr_ack_q, wr_ack_d;
    logic          rd_valid_q, rd_valid_d;
    logic          ovr_q, ovr_d;
    logic [15:0]   wdata_q, wdata_d;
    logic [15:0]   rdata_q, rdata_d;

    logic empty, full;
    logic wr_elig, rd_elig;
    logic starved, wr_win, ack_blk;

    assign empty   = (wp_q == rp_q);
    assign full    = ((wp_q + AW'(1)) == rp_q);
    assign wr_elig = bus.WR_REQ & ~full;
    assign rd_elig = bus.RD_REQ & ~empty;
    assign starved = (starve_q == SW'(STARVE_LIMIT));
    assign wr_win  = wr_elig & ~(rd_elig & starved);
    // The ack cycle is dead time so a requester can drop its request.
    assign ack_blk = wr_ack_q | rd_valid_q;

    // Next-state, grant and completion logic.
    always_comb begin
        state_d    = state_q;
        wp_d       = wp_q;
        rp_d       = rp_q;
        addr_d     = addr_q;
        starve_d   = starve_q;
        we_d       = we_q;
        wdata_d    = wdata_q;
        rdata_d    = rdata_q;
        ovr_d      = ovr_q;
        start_d    = 1'b0;
        wr_ack_d   = 1'b0;
        rd_valid_d = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (!ack_blk) begin
                    if (wr_win) begin
                        state_d = ISSUE;
                        start_d = 1'b1;
                        we_d    = 1'b1;
                        addr_d  = wp_q;
                        wdata_d = bus.WR_DATA;
                        if (bus.RD_REQ && !starved) begin
                            starve_d = starve_q + SW'(1);
                        end
                    end else if (rd_elig) begin
                        state_d  = ISSUE;
                        start_d  = 1'b1;
                        we_d     = 1'b0;
                        addr_d   = rp_q;
                        starve_d = '0;
                    end
                    // Refused write: flag it and ack without touching memory.
                    if (bus.WR_REQ && full) begin
                        ovr_d    = 1'b1;
                        wr_ack_d = 1'b1;
                    end
                end
            end
            ISSUE: begin
                state_d = WAIT_HI;
            end
            WAIT_HI: begin
                if (bus.MEM_BUSY) begin
                    state_d = WAIT_LO;
                end
            end
            WAIT_LO: begin
                if (!bus.MEM_BUSY) begin
                    state_d = IDLE;
                    if (we_q) begin
                        wr_ack_d = 1'b1;
                        wp_d     = wp_q + AW'(1);
                    end else begin
                        rd_valid_d = 1'b1;
                        rdata_d    = bus.MEM_RDATA;
                        rp_d       = rp_q + AW'(1);
                    end
                end
            end
        endcase
    end

    // State and datapath registers; reset abandons any access in flight.
    always_ff @(posedge CLK_48MHZ or negedge RESET) begin
        if (!RESET) begin
            state_q    <= IDLE;
            wp_q       <= '0;
            rp_q       <= '0;
            addr_q     <= '0;
            starve_q   <= '0;
            we_q       <= 1'b0;
            start_q    <= 1'b0;
            wr_ack_q   <= 1'b0;
            rd_valid_q <= 1'b0;
            ovr_q      <= 1'b0;
            wdata_q    <= '0;
            rdata_q    <= '0;
        end else begin
            state_q    <= state_d;
            wp_q       <= wp_d;
            rp_q       <= rp_d;
            addr_q     <= addr_d;
            starve_q   <= starve_d;
            we_q       <= we_d;
            start_q    <= start_d;
            wr_ack_q   <= wr_ack_d;
            rd_valid_q <= rd_valid_d;
            ovr_q      <= ovr_d;
            wdata_q    <= wdata_d;
            rdata_q    <= rdata_d;
        end
    end

    assign bus.MEM_START = start_q;
    assign bus.MEM_WE    = we_q;
    assign bus.MEM_ADDR  = addr_q;
    assign bus.MEM_WDATA = wdata_q;
    assign bus.WR_ACK    = wr_ack_q;
    assign bus.RD_VALID  = rd_valid_q;
    assign bus.RD_DATA   = rdata_q;
    assign bus.OVERRUN   = ovr_q;
    assign bus.EMPTY     = empty;
    assign bus.FULL      = full;
    assign bus.ROW_WRITE = wp_q[AW-1 -: ROW_BITS];
    assign bus.ROW_READ  = rp_q[AW-1 -: ROW_BITS];
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed and randomized checks of mem_arbiter
// against a FIFO-level reference model and a simple memory model.
module tb_mem_arbiter;
    localparam int RB    = 2;
    localparam int CB    = 2;
    localparam int AW    = RB + CB;
    localparam int DEPTH = 16;
    localparam int LIM   = 4;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;

    always #10 clk = ~clk;

    mem_arbiter_if #(.ROW_BITS(RB), .COL_BITS(CB)) bus ();

    mem_arbiter #(
        .ROW_BITS(RB),
        .COL_BITS(CB),
        .STARVE_LIMIT(LIM)
    ) dut (
        .CLK_48MHZ(clk),
        .RESET(rst_n),
        .bus(bus.slave)
    );

    int vec = 0;
    int miss = 0;
    int cyc = 0;

    int w_pending, r_pending;
    bit use_fixed;
    logic [15:0] fixed_wd, last_wd;
    int blen;

    logic [15:0] mem [DEPTH];
    bit start_pend;
    int busy_left, m_len;
    logic m_we;
    logic [AW-1:0] m_addr;

    logic [15:0] expq [$];
    bit glog [$];
    int mwp, mrp;
    int starts, w_starts, w_acks, r_valids;
    int w_ack_cyc, r_start_cyc, bstart_cyc, start_cyc, wreq_cyc;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        vec++;
        assert (obs === exp) else begin
            miss++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_flags(input string tag);
        chk({tag, "_empty"}, bus.EMPTY, mwp == mrp);
        chk({tag, "_full"}, bus.FULL, ((mwp + 1) % DEPTH) == mrp);
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, "_start"}, bus.MEM_START, 0);
        chk({tag, "_we"}, bus.MEM_WE, 0);
        chk({tag, "_addr"}, bus.MEM_ADDR, 0);
        chk({tag, "_wdata"}, bus.MEM_WDATA, 0);
        chk({tag, "_wrack"}, bus.WR_ACK, 0);
        chk({tag, "_rdvalid"}, bus.RD_VALID, 0);
        chk({tag, "_rddata"}, bus.RD_DATA, 0);
        chk({tag, "_overrun"}, bus.OVERRUN, 0);
        chk({tag, "_empty"}, bus.EMPTY, 1);
        chk({tag, "_full"}, bus.FULL, 0);
        chk({tag, "_roww"}, bus.ROW_WRITE, 0);
        chk({tag, "_rowr"}, bus.ROW_READ, 0);
    endtask

    task automatic clear_model();
        bus.WR_REQ    = 1'b0;
        bus.RD_REQ    = 1'b0;
        bus.MEM_BUSY  = 1'b0;
        bus.MEM_RDATA = 16'h0;
        bus.WR_DATA   = 16'h0;
        w_pending  = 0;
        r_pending  = 0;
        start_pend = 1'b0;
        busy_left  = 0;
        expq.delete();
        glog.delete();
        mwp = 0;
        mrp = 0;
        starts = 0;
        w_starts = 0;
        w_acks = 0;
        r_valids = 0;
    endtask

    // One clock: observe DUT, run memory model and requesters.
    task automatic tick();
        logic [15:0] exp_d;
        @(posedge clk);
        #1;
        cyc++;
        if (bus.WR_ACK) begin
            w_acks++;
            w_ack_cyc = cyc;
            if (((mwp + 1) % DEPTH) == mrp) begin
                chk("overrun_set", bus.OVERRUN, 1);
            end else begin
                expq.push_back(last_wd);
                mwp = (mwp + 1) % DEPTH;
            end
            chk_flags("wr_ack");
        end
        if (bus.RD_VALID) begin
            r_valids++;
            exp_d = (expq.size() > 0) ? expq.pop_front() : 16'hxxxx;
            chk("rd_data", bus.RD_DATA, exp_d);
            mrp = (mrp + 1) % DEPTH;
            chk_flags("rd_valid");
        end
        if (busy_left > 0) begin
            chk("addr_stable", {bus.MEM_WE, bus.MEM_ADDR}, {m_we, m_addr});
            busy_left--;
            if (busy_left == 0) begin
                bus.MEM_BUSY = 1'b0;
                if (!m_we) bus.MEM_RDATA = mem[m_addr];
            end
        end else if (start_pend) begin
            start_pend = 1'b0;
            bus.MEM_BUSY = 1'b1;
            busy_left = m_len;
            bstart_cyc = cyc;
        end
        if (bus.MEM_START) begin
            chk("single_access", int'(start_pend) + busy_left, 0);
            starts++;
            start_cyc = cyc;
            glog.push_back(bus.MEM_WE);
            m_we = bus.MEM_WE;
            m_addr = bus.MEM_ADDR;
            start_pend = 1'b1;
            m_len = (blen != 0) ? blen : int'($urandom_range(1, 4));
            if (m_we) begin
                w_starts++;
                chk("wr_addr", bus.MEM_ADDR, mwp);
                chk("wr_wdata", bus.MEM_WDATA, last_wd);
                mem[m_addr] = bus.MEM_WDATA;
            end else begin
                r_start_cyc = cyc;
                chk("rd_addr", bus.MEM_ADDR, mrp);
            end
        end
        if (bus.WR_ACK) begin
            bus.WR_REQ = 1'b0;
        end else if (!bus.WR_REQ && w_pending > 0) begin
            w_pending--;
            last_wd = use_fixed ? fixed_wd : 16'($urandom);
            bus.WR_DATA = last_wd;
            bus.WR_REQ = 1'b1;
            wreq_cyc = cyc;
        end
        if (bus.RD_VALID) begin
            bus.RD_REQ = 1'b0;
        end else if (!bus.RD_REQ && r_pending > 0) begin
            r_pending--;
            bus.RD_REQ = 1'b1;
        end
    endtask

    task automatic run_done(input int budget);
        int n;
        bit idle;
        n = 0;
        idle = 1'b0;
        while (!idle && n < budget) begin
            tick();
            n++;
            idle = (w_pending == 0) && (r_pending == 0) && !bus.WR_REQ
                && !bus.RD_REQ && busy_left == 0 && !start_pend;
        end
        chk("run_timeout", idle, 1);
    endtask

    task automatic do_reset();
        #3;
        rst_n = 1'b0;
        clear_model();
        #1;
        chk_reset("reset");
        repeat (2) tick();
        #5;
        rst_n = 1'b1;
    endtask

    initial begin
        int s0, v0, sv, n;
        bit exp_g [$];
        use_fixed = 1'b0;
        fixed_wd = 16'h0;
        last_wd = 16'h0;
        blen = 0;
        clear_model();

        // Power-on reset values.
        #2;
        do_reset();

        // Single write of A5C3 with a 3-cycle busy pulse.
        use_fixed = 1'b1;
        fixed_wd = 16'hA5C3;
        blen = 3;
        w_pending = 1;
        run_done(50);
        chk("w1_start_lat", start_cyc, wreq_cyc + 1);
        chk("w1_we", glog.size() == 1 && glog[0], 1);
        chk("w1_ack_lat", w_ack_cyc, bstart_cyc + 4);
        chk("w1_empty", bus.EMPTY, 0);
        chk("w1_roww", bus.ROW_WRITE, 0);

        // Read it back.
        glog.delete();
        r_pending = 1;
        run_done(50);
        chk("r1_we", glog.size() == 1 && !glog[0], 1);
        chk("r1_data", bus.RD_DATA, 16'hA5C3);
        chk("r1_empty", bus.EMPTY, 1);
        use_fixed = 1'b0;
        blen = 0;

        // Read on empty stays pending until a write lands.
        s0 = starts;
        v0 = r_valids;
        r_pending = 1;
        repeat (20) tick();
        chk("rempty_nostart", starts, s0);
        chk("rempty_novalid", r_valids, v0);
        glog.delete();
        w_pending = 1;
        run_done(60);
        chk("rempty_order", {glog.size() == 2, glog[0], glog[1]}, 3'b110);
        chk("rempty_grant", r_start_cyc, w_ack_cyc + 2);

        // Starvation guard with both requesters held busy.
        w_pending = 1;
        run_done(40);
        glog.delete();
        w_pending = 8;
        r_pending = 2;
        run_done(300);
        sv = 0;
        for (int k = 0; k < 10; k++) begin
            if (sv == LIM) begin
                exp_g.push_back(1'b0);
                sv = 0;
            end else begin
                exp_g.push_back(1'b1);
                sv++;
            end
        end
        chk("starve_count", glog.size(), 10);
        for (int k = 0; k < 10; k++) begin
            chk($sformatf("starve_g%0d", k), glog[k], exp_g[k]);
        end

        // Randomized traffic, never overfilling nor over-reading.
        for (int r = 0; r < 6; r++) begin
            n = (mwp - mrp + DEPTH) % DEPTH;
            w_pending = $urandom_range(0, DEPTH - 1 - n);
            r_pending = $urandom_range(0, n + w_pending);
            run_done(1000);
            repeat ($urandom_range(0, 3)) tick();
        end

        // Fill, overrun, and pointer wrap.
        do_reset();
        blen = 1;
        w_pending = 15;
        run_done(400);
        chk("fill_full", bus.FULL, 1);
        chk("fill_roww", bus.ROW_WRITE, 3);
        chk("fill_ovr", bus.OVERRUN, 0);
        chk("fill_starts", w_starts, 15);
        w_pending = 1;
        run_done(20);
        chk("ovr_set", bus.OVERRUN, 1);
        chk("ovr_nostart", w_starts, 15);
        chk("ovr_acks", w_acks, 16);
        r_pending = 1;
        run_done(30);
        chk("ovr_sticky", bus.OVERRUN, 1);
        chk("wrap_notfull", bus.FULL, 0);
        chk("wrap_rowr", bus.ROW_READ, 0);
        w_pending = 1;
        run_done(30);
        chk("wrap_roww", bus.ROW_WRITE, 0);
        chk("wrap_full", bus.FULL, 1);
        chk("wrap_starts", w_starts, 16);

        // Reset in the middle of WAIT_LO.
        blen = 4;
        r_pending = 1;
        s0 = starts;
        n = 0;
        while (starts == s0 && n < 20) begin
            tick();
            n++;
        end
        chk("mid_started", starts, s0 + 1);
        tick();
        tick();
        v0 = r_valids;
        #5;
        rst_n = 1'b0;
        #1;
        chk_reset("mid_reset");
        clear_model();
        repeat (3) begin
            tick();
            chk("mid_noack", {bus.WR_ACK, bus.RD_VALID}, 2'b00);
        end
        #5;
        rst_n = 1'b1;
        blen = 2;
        w_pending = 1;
        run_done(40);
        chk("mid_w_starts", w_starts, 1);
        chk("mid_w_acks", w_acks, 1);
        chk("mid_roww", bus.ROW_WRITE, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
        $finish;
    end
endmodule
